// File: rtl/rr_arb_4_pkg.sv
// Shared types and helpers for the four-way round-robin arbiter.
package rr_arb_4_pkg;

  localparam int NUM_REQ = 4;

  // Index of one requester; arithmetic on it wraps 3 -> 0 naturally.
  typedef logic [1:0] req_idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } rr_state_e;

  // Complete control state of the arbiter, kept together so a checker can
  // bind to one signal and see both the FSM state and the priority pointer.
  typedef struct packed {
    rr_state_e state;
    req_idx_t  ptr;
  } rr_ctrl_t;

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input req_idx_t idx);
    logic [NUM_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick_4.sv
// Combinational round-robin pick: the first set bit of elig, scanning from
// ptr upwards modulo four.
module rr_pick_4
  import rr_arb_4_pkg::*;
(
  input  logic [NUM_REQ-1:0] elig,
  input  req_idx_t           ptr,
  output logic               any,
  output req_idx_t           win
);

  logic [NUM_REQ-1:0] rot;
  req_idx_t           off;

  // Rotate elig so ptr lands at bit 0, priority-encode the lowest set bit,
  // then add ptr back to turn the offset into an absolute index.
  always_comb begin
    rot = NUM_REQ'({elig, elig} >> ptr);
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = req_idx_t'(i);
    end
    any = |elig;
    win = ptr + off;
  end

endmodule

// File: rtl/rr_arb_4.sv
// Four-way round-robin arbiter sharing one registered output word.
//
// Handshake: o_valid/i_ready are strict valid/ready. Once o_valid rises, o_sel
// and o_data are frozen until the cycle in which o_valid && i_ready, which is
// the transfer; o_valid then drops for one IDLE arbitration cycle. i_ready
// while o_valid is low is ignored. o_ack pulses for exactly one cycle, the
// first o_valid cycle, telling requester k its payload has been captured.
module rr_arb_4
  import rr_arb_4_pkg::*;
#(
  parameter int N = 64
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_REQ-1:0] i_en,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [N-1:0]       i_data0,
  input  logic [N-1:0]       i_data1,
  input  logic [N-1:0]       i_data2,
  input  logic [N-1:0]       i_data3,
  output logic [NUM_REQ-1:0] o_ack,
  output logic [1:0]         o_sel,
  output logic               o_valid,
  output logic [N-1:0]       o_data,
  input  logic               i_ready
);

  rr_ctrl_t           ctrl_q, ctrl_d;
  logic               valid_q, valid_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  req_idx_t           sel_q, sel_d;
  logic [N-1:0]       data_q, data_d;

  logic               any;
  req_idx_t           win;
  logic [N-1:0]       win_data;

  rr_pick_4 u_pick (
    .elig (i_req & i_en),
    .ptr  (ctrl_q.ptr),
    .any  (any),
    .win  (win)
  );

  // Payload of the winning requester.
  always_comb begin
    case (win)
      2'd0:    win_data = i_data0;
      2'd1:    win_data = i_data1;
      2'd2:    win_data = i_data2;
      default: win_data = i_data3;
    endcase
  end

  // Next-state logic: arbitrate in IDLE, hold the word until the transfer.
  always_comb begin
    ctrl_d  = ctrl_q;
    valid_d = valid_q;
    ack_d   = '0;
    sel_d   = sel_q;
    data_d  = data_q;
    case (ctrl_q.state)
      IDLE: begin
        if (any) begin
          data_d       = win_data;
          sel_d        = win;
          valid_d      = 1'b1;
          ack_d        = idx_to_onehot(win);
          ctrl_d.ptr   = win + 2'd1;
          ctrl_d.state = HOLD;
        end
      end
      HOLD: begin
        // Requests and enables are ignored here; only the sink matters.
        if (valid_q && i_ready) begin
          valid_d      = 1'b0;
          ctrl_d.state = IDLE;
        end
      end
      default: ctrl_d.state = IDLE;
    endcase
  end

  // State and output registers; reset discards any held word at once.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ctrl_q  <= '{state: IDLE, ptr: 2'd0};
      valid_q <= 1'b0;
      ack_q   <= '0;
      sel_q   <= '0;
      data_q  <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
    end
  end

  assign o_ack   = ack_q;
  assign o_sel   = sel_q;
  assign o_valid = valid_q;
  assign o_data  = data_q;

endmodule

// File: tb/tb_rr_arb_4.sv
// Directed bench for rr_arb_4: the stimulus pushes the expected {sel, data}
// of each grant into exp_q, a monitor pops and compares on each new word.
module tb_rr_arb_4;
  import rr_arb_4_pkg::*;

  localparam int N = 64;
  localparam int W = N + 2;

  // ---------------- clock / reset ----------------
  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic [3:0]   i_en = 4'b1111;
  logic [3:0]   i_req = 4'b0000;
  logic [N-1:0] i_data0 = '0;
  logic [N-1:0] i_data1 = '0;
  logic [N-1:0] i_data2 = '0;
  logic [N-1:0] i_data3 = '0;
  logic         i_ready = 1'b1;
  logic [3:0]   o_ack;
  logic [1:0]   o_sel;
  logic         o_valid;
  logic [N-1:0] o_data;

  always #5 i_clk = ~i_clk;

  rr_arb_4 #(.N(N)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (i_en),
    .i_req   (i_req),
    .i_data0 (i_data0),
    .i_data1 (i_data1),
    .i_data2 (i_data2),
    .i_data3 (i_data3),
    .o_ack   (o_ack),
    .o_sel   (o_sel),
    .o_valid (o_valid),
    .o_data  (o_data),
    .i_ready (i_ready)
  );

  // Standalone instance of the picker for an exhaustive table check.
  logic [3:0] t_elig = '0;
  req_idx_t   t_ptr = '0;
  logic       t_any;
  req_idx_t   t_win;

  rr_pick_4 u_pick_chk (
    .elig (t_elig),
    .ptr  (t_ptr),
    .any  (t_any),
    .win  (t_win)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pack(input logic [1:0] sel,
                                        input logic [N-1:0] data);
    return {sel, data};
  endfunction

  // Monitor: first cycle of each word is compared with the queue head;
  // later cycles of the same word must be stable with o_ack low.
  logic         prev_valid = 1'b0;
  logic [W-1:0] hold_exp = '0;

  initial begin
    logic [W-1:0] cur;
    forever begin
      @(negedge i_clk);
      if (o_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got sel=%0d data=%0h, none expected",
                   o_sel, o_data);
        end else begin
          cur = exp_q.pop_front();
          check("word_sel", W'(o_sel), W'(cur[N+1:N]));
          check("word_data", W'(o_data), W'(cur[N-1:0]));
          check("word_ack", W'(o_ack), W'(idx_to_onehot(cur[N+1:N])));
          hold_exp = cur;
        end
      end else if (o_valid) begin
        check("hold_stable", pack(o_sel, o_data), hold_exp);
        check("hold_ack_low", W'(o_ack), '0);
      end
      prev_valid = o_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic pulse_reset();
    i_rst_n = 1'b0;
    #2;
    i_rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Picker table against a plain sequential scan.
    for (int e = 0; e < 16; e++) begin
      for (int p = 0; p < 4; p++) begin
        logic [1:0] m_win;
        logic       found;
        t_elig = 4'(e);
        t_ptr  = 2'(p);
        found  = 1'b0;
        m_win  = '0;
        for (int k = 0; k < 4; k++) begin
          if (!found && t_elig[(p + k) % 4]) begin
            found = 1'b1;
            m_win = 2'((p + k) % 4);
          end
        end
        #1;
        check("pick_any", W'(t_any), W'(found));
        if (found) check("pick_win", W'(t_win), W'(m_win));
      end
    end

    // Reset state.
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_valid", W'(o_valid), '0);
    check("rst_ack", W'(o_ack), '0);
    check("rst_sel", W'(o_sel), '0);
    check("rst_data", W'(o_data), '0);
    i_rst_n = 1'b1;
    step();

    // Single request from requester 0, then ptr must favour 1.
    i_req = 4'b0001; i_data0 = 64'hAA;
    exp_q.push_back(pack(2'd0, 64'hAA));
    step();
    check("t1_latency_valid", W'(o_valid), W'(1));
    i_req = 4'b0000;
    step();
    check("t1_after_xfer", W'(o_valid), '0);
    i_req = 4'b0011; i_data1 = 64'hBB;
    exp_q.push_back(pack(2'd1, 64'hBB));
    step();
    check("t1_ptr1_valid", W'(o_valid), W'(1));
    i_req = 4'b0000;
    step();

    // All four requesting continuously: 0,1,2,3,0, one word per 2 cycles.
    pulse_reset();
    i_data0 = 64'h1000; i_data1 = 64'h1111;
    i_data2 = 64'h2222; i_data3 = 64'h3333;
    exp_q.push_back(pack(2'd0, 64'h1000));
    exp_q.push_back(pack(2'd1, 64'h1111));
    exp_q.push_back(pack(2'd2, 64'h2222));
    exp_q.push_back(pack(2'd3, 64'h3333));
    exp_q.push_back(pack(2'd0, 64'h1000));
    i_req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t2_valid_on", W'(o_valid), W'(1));
      if (i == 4) i_req = 4'b0000;
      step();
      check("t2_valid_off", W'(o_valid), '0);
    end

    // Enables 1010: only 1 and 3 alternate.
    pulse_reset();
    i_en = 4'b1010;
    exp_q.push_back(pack(2'd1, 64'h1111));
    exp_q.push_back(pack(2'd3, 64'h3333));
    exp_q.push_back(pack(2'd1, 64'h1111));
    i_req = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t3_masked_ack", W'(o_ack & 4'b0101), '0);
      if (i == 2) i_req = 4'b0000;
      step();
    end
    i_en = 4'b1111;

    // Sink stall: word held, late request from 2 waits for the transfer.
    pulse_reset();
    i_ready = 1'b0;
    i_req = 4'b0001; i_data0 = 64'hC0DE;
    exp_q.push_back(pack(2'd0, 64'hC0DE));
    step();
    i_req = 4'b0100; i_data0 = 64'hDEAD; i_data2 = 64'h2B2B;
    exp_q.push_back(pack(2'd2, 64'h2B2B));
    for (int i = 0; i < 5; i++) begin
      step();
      check("t4_stall_valid", W'(o_valid), W'(1));
      check("t4_stall_sel", W'(o_sel), '0);
    end
    i_ready = 1'b1;
    step();
    check("t4_xfer_done", W'(o_valid), '0);
    step();
    check("t4_req2_valid", W'(o_valid), W'(1));
    check("t4_req2_sel", W'(o_sel), W'(2));
    i_req = 4'b0000;
    step();

    // Wrap-around: grant 2 moves ptr to 3; then 1001 gives 3, then 0.
    pulse_reset();
    i_data0 = 64'h0A0A; i_data2 = 64'h2C2C; i_data3 = 64'h3D3D;
    exp_q.push_back(pack(2'd2, 64'h2C2C));
    exp_q.push_back(pack(2'd3, 64'h3D3D));
    exp_q.push_back(pack(2'd0, 64'h0A0A));
    i_req = 4'b0100;
    step();
    i_req = 4'b0000;
    step();
    i_req = 4'b1001;
    step();
    check("t5_wrap_sel3", W'(o_sel), W'(3));
    i_req = 4'b0001;
    step();
    step();
    check("t5_wrap_sel0", W'(o_sel), W'(0));
    i_req = 4'b0000;
    step();

    // Asynchronous reset in the first HOLD cycle, between clock edges.
    i_ready = 1'b0;
    i_req = 4'b0001; i_data0 = 64'h5555;
    exp_q.push_back(pack(2'd0, 64'h5555));
    step();
    i_req = 4'b0000;
    check("t6_pre_rst_ack", W'(o_ack), W'(4'b0001));
    #1;
    i_rst_n = 1'b0;
    #1;
    check("t6_rst_valid", W'(o_valid), '0);
    check("t6_rst_ack", W'(o_ack), '0);
    exp_q.delete();
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    i_req = 4'b0100; i_data2 = 64'h6262;
    exp_q.push_back(pack(2'd2, 64'h6262));
    step();
    check("t6_first_grant", W'(o_sel), W'(2));
    i_req = 4'b0000;
    step();

    repeat (3) step();
    check("queue_empty", W'(exp_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
